// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  // Occupancy value at which the RAM region holds no free entry.
  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-port RAM. Reads take priority
// over writes, a one-cycle read-pending flag spaces reads apart so writes are
// never starved, and the FIFO head lives in a dedicated output register.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  addr_t wr_ptr_q, wr_ptr_d;
  addr_t rd_ptr_q, rd_ptr_d;
  cnt_t  mem_cnt_q, mem_cnt_d;
  logic  rd_pend_q, rd_pend_d;
  logic  out_valid_q, out_valid_d;
  data_t out_data_q, out_data_d;

  logic  rd_go;
  logic  wr_go;

  // Arbitrate the single RAM port: issue a read whenever the head register
  // will have room when the data returns, otherwise grant the writer.
  always_comb begin
    rd_go    = (mem_cnt_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    in_ready = (mem_cnt_q != DEPTH_CNT) && !rd_go;
    wr_go    = in_valid && in_ready;
  end

  // Drive the RAM port; the address follows whichever operation owns the cycle.
  always_comb begin
    ram_addr = rd_go ? rd_ptr_q : wr_ptr_q;
    ram_data = in_data;
    ram_we   = wr_go;
  end

  // Next-state for pointers, occupancy, the in-flight read and the head register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    rd_pend_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (wr_go) begin
      wr_ptr_d  = wr_ptr_q + addr_t'(1);
      mem_cnt_d = mem_cnt_q + cnt_t'(1);
    end

    if (rd_go) begin
      rd_ptr_d  = rd_ptr_q + addr_t'(1);
      mem_cnt_d = mem_cnt_q - cnt_t'(1);
      rd_pend_d = 1'b1;
    end

    if (rd_pend_q) begin
      out_data_d  = ram_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; RAM contents are left alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Status outputs derived from the registered state.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    count     = mem_cnt_q + cnt_t'(rd_pend_q) + cnt_t'(out_valid_q);
    full      = (mem_cnt_q == DEPTH_CNT);
    empty     = (count == '0);
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl paired with a behavioural 64x8 single-port RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [6:0] count;
  logic       full;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Single-port RAM: write on we, otherwise register the address for next-cycle q.
  logic [7:0] mem [0:63];
  logic [5:0] ram_raddr_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        ram_raddr_q   <= ram_addr;
  end

  assign ram_q = mem[ram_raddr_q];

  // Hard stop in case a scenario never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic push_one(input logic [7:0] v, output bit ok);
    int n;
    ok       = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!ok && n < 8) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, empty, full, count, in_ready} !== {1'b0, 1'b1, 1'b0, 7'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_state: got ov/empty/full/count/in_ready=%b/%b/%b/%0d/%b expected 0/1/0/0/1",
               out_valid, empty, full, count, in_ready);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, empty, count, ram_we} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL idle_cycle%0d: got ov/empty/count/we=%b/%b/%0d/%b expected 0/1/0/0",
                 i, out_valid, empty, count, ram_we);
      end
      tick();
    end
  endtask

  task automatic test_single_push();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, 6'd0}) begin
      failures++;
      $display("[TB] FAIL single_write: got we/addr=%b/%0d expected 1/0", ram_we, ram_addr);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr, in_ready} !== {1'b0, 6'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL single_read_issue: got we/addr/in_ready=%b/%0d/%b expected 0/0/0",
               ram_we, ram_addr, in_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, count} !== {1'b0, 7'd1}) begin
      failures++;
      $display("[TB] FAIL single_inflight: got ov/count=%b/%0d expected 0/1", out_valid, count);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL single_head: got ov/data=%b/%h expected 1/a5", out_valid, out_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({out_valid, empty, count} !== {1'b0, 1'b1, 7'd0}) begin
      failures++;
      $display("[TB] FAIL single_after_pop: got ov/empty/count=%b/%b/%0d expected 0/1/0",
               out_valid, empty, count);
    end
    tick();
  endtask

  task automatic test_fill();
    int accepted;
    bit ok;
    do_reset();
    out_ready = 1'b0;
    accepted  = 0;
    for (int v = 0; v <= 8'h40; v++) begin
      push_one(8'(v), ok);
      if (ok) accepted++;
    end
    @(negedge clk);
    checks++;
    if (accepted != 65 || count !== 7'd65 || full !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_state: got accepted/count/full/in_ready=%0d/%0d/%b/%b expected 65/65/1/0",
               accepted, count, full, in_ready);
    end
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
      failures++;
      $display("[TB] FAIL fill_head_hold: got ov/data=%b/%h expected 1/00", out_valid, out_data);
    end
    tick();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_we, in_ready, count} !== {1'b0, 1'b0, 7'd65}) begin
        failures++;
        $display("[TB] FAIL push_while_full%0d: got we/in_ready/count=%b/%b/%0d expected 0/0/65",
                 i, ram_we, in_ready, count);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Continues from the full state left by test_fill.
  task automatic test_drain_wrap();
    int got;
    int n;
    got       = 0;
    n         = 0;
    out_ready = 1'b1;
    while (got < 65 && n < 400) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_data !== 8'(got)) begin
          failures++;
          $display("[TB] FAIL drain_order%0d: got %h expected %h", got, out_data, 8'(got));
        end
        got++;
      end
      tick();
      n++;
    end
    checks++;
    if (got != 65) begin
      failures++;
      $display("[TB] FAIL drain_count: got %0d expected 65", got);
    end
    @(negedge clk);
    checks++;
    if ({empty, count, out_valid} !== {1'b1, 7'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL drain_empty: got empty/count/ov=%b/%0d/%b expected 1/0/0",
               empty, count, out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] next_wr;
    logic [7:0] exp_v;
    logic [5:0] wr_addr;
    logic [5:0] rd_addr;
    bit         prev_low;
    int         writes;
    int         n;
    do_reset();
    q         = {};
    next_wr   = 8'h00;
    wr_addr   = 6'd0;
    rd_addr   = 6'd0;
    prev_low  = 1'b0;
    writes    = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      in_data = next_wr;
      @(negedge clk);
      if (out_valid) begin
        checks++;
        exp_v = (q.size() > 0) ? q.pop_front() : 8'hXX;
        if (out_data !== exp_v) begin
          failures++;
          $display("[TB] FAIL stream_order c%0d: got %h expected %h", cyc, out_data, exp_v);
        end
      end
      checks++;
      if (in_ready) begin
        if ({ram_we, ram_addr} !== {1'b1, wr_addr}) begin
          failures++;
          $display("[TB] FAIL stream_write c%0d: got we/addr=%b/%0d expected 1/%0d",
                   cyc, ram_we, ram_addr, wr_addr);
        end
        q.push_back(next_wr);
        next_wr  = next_wr + 8'd1;
        wr_addr  = wr_addr + 6'd1;
        writes++;
        prev_low = 1'b0;
      end else begin
        if ({ram_we, ram_addr, prev_low} !== {1'b0, rd_addr, 1'b0}) begin
          failures++;
          $display("[TB] FAIL stream_read c%0d: got we/addr/prev_low=%b/%0d/%b expected 0/%0d/0",
                   cyc, ram_we, ram_addr, prev_low, rd_addr);
        end
        rd_addr  = rd_addr + 6'd1;
        prev_low = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        exp_v = q.pop_front();
        if (out_data !== exp_v) begin
          failures++;
          $display("[TB] FAIL stream_drain: got %h expected %h", out_data, exp_v);
        end
      end
      tick();
      n++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0 || writes < 100 || count !== 7'd0) begin
      failures++;
      $display("[TB] FAIL stream_totals: got left/writes/count=%0d/%0d/%0d expected 0/>=100/0",
               q.size(), writes, count);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n;
    bit seen;
    do_reset();
    out_ready = 1'b0;
    for (int v = 0; v < 5; v++) push_one(8'h10 + 8'(v), ok);
    tick();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({count, out_valid, out_data} !== {7'd5, 1'b1, 8'h10}) begin
      failures++;
      $display("[TB] FAIL midrst_queued: got count/ov/data=%0d/%b/%h expected 5/1/10",
               count, out_valid, out_data);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, out_valid} !== {7'd4, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midrst_inflight: got count/ov=%0d/%b expected 4/0", count, out_valid);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({count, out_valid, empty, full, ram_addr} !== {7'd0, 1'b0, 1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("[TB] FAIL midrst_cleared: got count/ov/empty/full/addr=%0d/%b/%b/%b/%0d expected 0/0/1/0/0",
               count, out_valid, empty, full, ram_addr);
    end
    tick();
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, 6'd0}) begin
      failures++;
      $display("[TB] FAIL midrst_push: got we/addr=%b/%0d expected 1/0", ram_we, ram_addr);
    end
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        checks++;
        if (out_data !== 8'h3C) begin
          failures++;
          $display("[TB] FAIL midrst_readback: got %h expected 3c", out_data);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL midrst_timeout: got no out_valid expected out_valid within 10 cycles");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the 64x8 single-port RAM (8-bit data, 6-bit addr, we, registered read address, q).
- Converts a valid/ready push stream and a valid/ready pop stream into the RAM's one-operation-per-cycle port.
- Keeps read/write pointers and occupancy, and holds the FIFO head in an output register.
- The RAM is instantiated beside this block by the parent; the block does not contain storage beyond the head register.

Parameters:
- DATA_W, 8, data width; must match RAM data width.
- ADDR_W, 6, RAM address width.
- DEPTH, 64, RAM entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_W  push data.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  out_data valid.
- out_ready  in  1  pop when out_valid && out_ready.
- ram_data  out  DATA_W  to RAM data.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_W  from RAM q.
- count  out  ADDR_W+1  total occupancy (RAM + read in flight + head register), 0..DEPTH+1.
- full  out  1  RAM region full (mem_cnt == DEPTH).
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n low at posedge):
  - wr_ptr, rd_ptr, mem_cnt (ADDR_W+1 bits), rd_pend, out_valid, out_data all 0.
  - count 0, full 0, empty 1.
  - RAM contents are not cleared and are irrelevant.
- RAM timing contract:
  - we=1 writes ram[addr] at the edge.
  - we=0 latches addr at the edge; q shows that entry the following cycle.
  - Read data is therefore sampled one cycle after the read is issued.
- Read issue (combinational): rd_go = (mem_cnt != 0) && !rd_pend && (!out_valid || out_ready).
- Write issue: in_ready = (mem_cnt != DEPTH) && !rd_go. ram_we = in_valid && in_ready.
- Port mux:
  - ram_addr = rd_go ? rd_ptr : wr_ptr.
  - ram_data = in_data, always driven.
  - ram_we = 0 whenever rd_go = 1.
- Arbitration:
  - Read has priority.
  - rd_pend blocks back-to-back reads, so writes are granted at least every other cycle; no starvation.
- Registered updates:
  - On write: wr_ptr+1 (wraps DEPTH-1 -> 0), mem_cnt+1.
  - On rd_go: rd_ptr+1 (wraps), mem_cnt-1, rd_pend <= 1.
  - A write and rd_go never occur in the same cycle.
  - When rd_pend = 1: out_data <= ram_q, out_valid <= 1, rd_pend <= 0.
  - Else if out_valid && out_ready: out_valid <= 0; out_data holds its value.
- Latency:
  - Push at cycle T into an empty FIFO: rd_go at T+1, out_valid high at T+3.
  - Steady-state throughput: 1 item per 2 cycles.
- count = mem_cnt + rd_pend + out_valid. full and empty are combinational from the registers.
- Boundaries:
  - Push while full: in_ready = 0, nothing written.
  - Pop while empty: out_valid = 0, no effect.
  - Upstream must hold in_data stable while in_valid && !in_ready.
  - out_data must stay stable while out_valid && !out_ready.
  - Wrap-around is invisible: FIFO order is preserved across the pointer wrap.
  - Reset asserted mid-read drops the in-flight word and all contents.

Decomposition:
- Package ram_fifo_pkg:
  - localparams DATA_W, ADDR_W, DEPTH.
  - typedefs data_t (logic [DATA_W-1:0]), addr_t (logic [ADDR_W-1:0]), cnt_t (logic [ADDR_W:0]).
- No sub-module: pointer/counter logic is small and flat.
- The bench wraps ram_fifo_ctrl together with the single-port RAM.

Test Plan:
- Reset, then idle with out_ready=1 for 10 cycles -> out_valid=0, empty=1, count=0, ram_we=0 throughout.
- Single push 0xA5 at cycle T, out_ready=1 -> ram_we=1 with ram_addr=0 at T; ram_addr=0 with ram_we=0 at T+1; out_valid=1 and out_data=0xA5 at T+3; empty=1 after the pop.
- out_ready=0, push 0x00..0x40 continuously -> 65 pushes accepted; count=65, full=1; in_ready=0 afterwards and ram_we stays 0.
- From that full state, raise out_ready and pop all -> data 0x00..0x40 in order, including across the rd_ptr wrap 63->0; empty=1 at the end.
- in_valid=1 and out_ready=1 held for 200 cycles with incrementing data -> order preserved, no beat lost, in_ready low exactly in the rd_go cycles, ≥1 write every 2 cycles.
- rst_n low for one cycle while rd_pend=1 with 5 entries queued -> next cycle count=0, out_valid=0, pointers 0; a following push 0x3C is read back as 0x3C.
